// File: rtl/jtadpcm_seq.sv
// Time-multiplexed ADPCM sample sequencer: walks CH channels through ROM nibbles,
// handles start/abort/loop requests and serializes the nibble stream.
module jtadpcm_seq #(
  parameter int CH   = 4,
  parameter int AW   = 18,
  parameter int ATTW = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cen4,
  input  logic [CH-1:0]         start,
  input  logic [CH-1:0]         stop,
  input  logic [CH-1:0]         loop,
  input  logic [AW-1:0]         start_addr,
  input  logic [AW-1:0]         stop_addr,
  input  logic [ATTW-1:0]       att,
  output logic [CH-1:0]         busy,
  output logic [CH-1:0]         eos,
  output logic                  zero,
  output logic [AW-1:0]         rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  pipe_en,
  output logic [$clog2(CH)-1:0] pipe_ch,
  output logic [ATTW-1:0]       pipe_att,
  output logic [3:0]            pipe_data
);
  localparam int CW = $clog2(CH);
  localparam logic [CW-1:0] LAST_SLOT = CW'(CH - 1);

  logic [CW-1:0]   r_slot;
  logic [AW:0]     r_cnt     [CH];
  logic [AW-1:0]   r_stop_a  [CH];
  logic [AW-1:0]   r_start_a [CH];
  logic [ATTW-1:0] r_att     [CH];
  logic [CH-1:0]   r_loop, r_busy, r_eos, r_pst, r_pab;

  logic [AW-1:0]   r_h_start, r_h_stop;
  logic [ATTW-1:0] r_h_att;
  logic [CH-1:0]   r_h_loop;

  logic            r_a_en, r_a_sel, r_b_en, r_b_sel;
  logic [CW-1:0]   r_a_ch, r_b_ch;
  logic [ATTW-1:0] r_a_att, r_b_att;
  logic [7:0]      r_b_data;

  logic            r_pipe_en;
  logic [CW-1:0]   r_pipe_ch;
  logic [ATTW-1:0] r_pipe_att;
  logic [3:0]      r_pipe_data;

  logic [AW:0]     w_cnt, w_nxt_cnt;
  logic            w_nxt_busy, w_set_eos, w_load, w_at_end;
  logic [ATTW-1:0] w_nxt_att;
  logic [CH-1:0]   w_onehot;

  assign w_cnt    = r_cnt[r_slot];
  assign rom_addr = w_cnt[AW:1];
  assign w_at_end = (rom_addr >= r_stop_a[r_slot]);
  assign w_onehot = {{(CH-1){1'b0}}, 1'b1} << r_slot;
  assign zero     = (r_slot == LAST_SLOT);

  // Next state of the channel served in this slot; a pending start beats an abort
  always_comb begin
    w_nxt_cnt  = w_cnt;
    w_nxt_busy = r_busy[r_slot];
    w_set_eos  = 1'b0;
    w_load     = 1'b0;
    if (r_pst[r_slot]) begin
      w_nxt_cnt  = {r_h_start, 1'b0};
      w_nxt_busy = 1'b1;
      w_load     = 1'b1;
    end else if (r_pab[r_slot]) begin
      w_nxt_busy = 1'b0;
    end else if (r_busy[r_slot]) begin
      if (!w_at_end) begin
        w_nxt_cnt = w_cnt + 1'b1;
      end else begin
        w_set_eos = 1'b1;
        if (r_loop[r_slot]) begin
          w_nxt_cnt = {r_start_a[r_slot], 1'b0};
        end else begin
          w_nxt_busy = 1'b0;
        end
      end
    end else begin
      w_nxt_busy = 1'b0;
    end
    w_nxt_att = w_load ? r_h_att : r_att[r_slot];
  end

  // Slot sequencing, channel state, request capture and the two-stage nibble pipeline
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_slot <= '0;
      for (int i = 0; i < CH; i++) begin
        r_cnt[i]     <= '0;
        r_stop_a[i]  <= '0;
        r_start_a[i] <= '0;
        r_att[i]     <= '0;
      end
      r_loop      <= '0;
      r_busy      <= '0;
      r_eos       <= '0;
      r_pst       <= '0;
      r_pab       <= '0;
      r_h_start   <= '0;
      r_h_stop    <= '0;
      r_h_att     <= '0;
      r_h_loop    <= '0;
      r_a_en      <= 1'b0;
      r_a_sel     <= 1'b0;
      r_a_ch      <= '0;
      r_a_att     <= '0;
      r_b_en      <= 1'b0;
      r_b_sel     <= 1'b0;
      r_b_ch      <= '0;
      r_b_att     <= '0;
      r_b_data    <= 8'h00;
      r_pipe_en   <= 1'b0;
      r_pipe_ch   <= '0;
      r_pipe_att  <= '0;
      r_pipe_data <= 4'h0;
    end else if (cen4) begin
      r_slot         <= zero ? '0 : r_slot + 1'b1;
      r_cnt[r_slot]  <= w_nxt_cnt;
      r_busy[r_slot] <= w_nxt_busy;
      r_eos          <= w_set_eos ? w_onehot : '0;
      if (w_load) begin
        r_stop_a[r_slot]  <= r_h_stop;
        r_start_a[r_slot] <= r_h_start;
        r_att[r_slot]     <= r_h_att;
        r_loop[r_slot]    <= r_h_loop[r_slot];
      end
      // The last slot is served with the old holding set while the new one is captured
      r_pst <= (r_pst & ~w_onehot) | (zero ? start : '0);
      r_pab <= (r_pab & ~w_onehot) | (zero ? stop : '0);
      if (zero) begin
        r_h_start <= start_addr;
        r_h_stop  <= stop_addr;
        r_h_att   <= att;
        r_h_loop  <= loop;
      end
      r_a_en      <= w_nxt_busy;
      r_a_sel     <= w_cnt[0];
      r_a_ch      <= r_slot;
      r_a_att     <= w_nxt_att;
      r_b_en      <= r_a_en;
      r_b_sel     <= r_a_sel;
      r_b_ch      <= r_a_ch;
      r_b_att     <= r_a_att;
      r_b_data    <= rom_data;
      r_pipe_en   <= r_b_en;
      r_pipe_ch   <= r_b_ch;
      r_pipe_att  <= r_b_att;
      r_pipe_data <= r_b_sel ? r_b_data[3:0] : r_b_data[7:4];
    end
  end

  assign busy      = r_busy;
  assign eos       = r_eos;
  assign pipe_en   = r_pipe_en;
  assign pipe_ch   = r_pipe_ch;
  assign pipe_att  = r_pipe_att;
  assign pipe_data = r_pipe_data;
endmodule
